// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM keypad front end: state encoding,
// special key codes and the account-field width.
package atm_pkg;

  typedef enum logic [2:0] {
    ID_ENTRY   = 3'd0,
    PASS_ENTRY = 3'd1,
    PRESENT    = 3'd2,
    WAIT_AUTH  = 3'd3,
    SESSION    = 3'd4,
    LOCKED     = 3'd5
  } atm_state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam int         ACCT_W    = 8;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Keypad, credential and authentication signals between the ATM controller
// (master) and the keypad front end (slave).
interface atm_keypad_frontend_if;
  import atm_pkg::*;

  logic              KeyValid;
  logic [3:0]        KeyCode;
  logic              CredReady;
  logic              AuthValid;
  logic              AuthFail;
  logic              SessionEnd;
  logic [ACCT_W-1:0] ID;
  logic [ACCT_W-1:0] Password;
  logic              CredValid;
  logic              EntryErr;
  logic              Locked;
  logic [2:0]        TriesLeft;
  logic [2:0]        Stage;

  // Credentials transfer on a rising edge with CredValid && CredReady; ID and
  // Password never change while CredValid is high, and CredValid only drops
  // on an auth failure or the end of the session.
  modport master (
    output KeyValid, KeyCode, CredReady, AuthValid, AuthFail, SessionEnd,
    input  ID, Password, CredValid, EntryErr, Locked, TriesLeft, Stage
  );

  modport slave (
    input  KeyValid, KeyCode, CredReady, AuthValid, AuthFail, SessionEnd,
    output ID, Password, CredValid, EntryErr, Locked, TriesLeft, Stage
  );

endinterface

// File: rtl/atm_digit_accum.sv
// Decimal entry accumulator: up to three digits into a 10-bit value, with a
// synchronous clear and an above-field-range flag.
module atm_digit_accum
  import atm_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              clear,
  input  logic              digit_valid,
  input  logic [3:0]        digit,
  output logic [ACCT_W-1:0] value,
  output logic [1:0]        count,
  output logic              overflow
);

  logic [9:0] value_q;
  logic [1:0] count_q;

  // Three digits top out at 999, so the 10-bit product never wraps.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      value_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      value_q <= '0;
      count_q <= '0;
    end else if (digit_valid && count_q != 2'd3) begin
      value_q <= value_q * 10'd10 + {6'd0, digit};
      count_q <= count_q + 2'd1;
    end
  end

  assign value    = value_q[ACCT_W-1:0];
  assign count    = count_q;
  assign overflow = value_q > 10'd255;

endmodule

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: collects ID and password digits, presents them with a
// valid/ready handshake and enforces a failed-attempt lockout.
// Optional idle timeout during entry: define ATM_KEYPAD_TIMEOUT_EN.
module atm_keypad_frontend
  import atm_pkg::*;
#(
  parameter int MAX_TRIES     = 3,
  parameter int LOCK_CYCLES   = 1000,
  parameter int DIGIT_TIMEOUT = 500
) (
  input logic                  Clock,
  input logic                  Reset,
  atm_keypad_frontend_if.slave bus
);

  localparam int               LOCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       TRIES_INIT = 3'(MAX_TRIES);

  atm_state_e        state_q, state_d;
  logic [ACCT_W-1:0] id_q, id_d, pw_q, pw_d;
  logic [2:0]        tries_q, tries_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              err_q, err_d;

  logic              acc_clear, acc_digit, acc_overflow;
  logic [ACCT_W-1:0] acc_value;
  logic [1:0]        acc_count;
  logic              in_entry, timeout;

  assign in_entry = (state_q == ID_ENTRY) || (state_q == PASS_ENTRY);

  atm_digit_accum u_accum (
    .Clock       (Clock),
    .Reset       (Reset),
    .clear       (acc_clear),
    .digit_valid (acc_digit),
    .digit       (bus.KeyCode),
    .value       (acc_value),
    .count       (acc_count),
    .overflow    (acc_overflow)
  );

`ifdef ATM_KEYPAD_TIMEOUT_EN
  localparam int                IDLE_W    = (DIGIT_TIMEOUT > 1) ? $clog2(DIGIT_TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DIGIT_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q;

  // Saturates at the limit so an empty ID_ENTRY simply keeps waiting.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idle_q <= '0;
    end else if (!in_entry || bus.KeyValid || timeout) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  assign timeout = in_entry && !bus.KeyValid && (idle_q == IDLE_LAST) &&
                   ((acc_value != '0) || acc_overflow || (state_q == PASS_ENTRY));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ID_ENTRY;
      id_q       <= '0;
      pw_q       <= '0;
      tries_q    <= TRIES_INIT;
      lock_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      pw_q       <= pw_d;
      tries_q    <= tries_d;
      lock_cnt_q <= lock_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    pw_d       = pw_q;
    tries_d    = tries_q;
    lock_cnt_d = '0;
    err_d      = 1'b0;
    acc_clear  = 1'b0;
    acc_digit  = 1'b0;

    // SessionEnd outranks keys and auth results everywhere except LOCKED.
    if (bus.SessionEnd && state_q != LOCKED) begin
      state_d   = ID_ENTRY;
      id_d      = '0;
      pw_d      = '0;
      acc_clear = 1'b1;
      if (state_q == SESSION) tries_d = TRIES_INIT;
    end else begin
      case (state_q)
        ID_ENTRY, PASS_ENTRY: begin
          if (timeout) begin
            state_d   = ID_ENTRY;
            id_d      = '0;
            pw_d      = '0;
            acc_clear = 1'b1;
            err_d     = 1'b1;
          end else if (bus.KeyValid) begin
            if (is_digit(bus.KeyCode)) begin
              acc_digit = 1'b1;
            end else if (bus.KeyCode == KEY_CLEAR) begin
              acc_clear = 1'b1;
            end else if (bus.KeyCode == KEY_ENTER && acc_count != 2'd0) begin
              acc_clear = 1'b1;
              if (acc_overflow) begin
                err_d = 1'b1;
              end else if (state_q == ID_ENTRY) begin
                id_d    = acc_value;
                state_d = PASS_ENTRY;
              end else begin
                pw_d    = acc_value;
                state_d = PRESENT;
              end
            end
          end
        end
        PRESENT: begin
          if (bus.CredReady) state_d = WAIT_AUTH;
        end
        WAIT_AUTH: begin
          if (bus.AuthValid) begin
            if (!bus.AuthFail) begin
              state_d = SESSION;
            end else begin
              tries_d = tries_q - 3'd1;
              id_d    = '0;
              pw_d    = '0;
              state_d = (tries_q == 3'd1) ? LOCKED : ID_ENTRY;
            end
          end
        end
        SESSION: ;
        LOCKED: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d = ID_ENTRY;
            tries_d = TRIES_INIT;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        default: state_d = ID_ENTRY;
      endcase
    end
  end

  assign bus.ID        = id_q;
  assign bus.Password  = pw_q;
  assign bus.CredValid = (state_q == PRESENT) || (state_q == WAIT_AUTH) || (state_q == SESSION);
  assign bus.EntryErr  = err_q;
  assign bus.Locked    = (state_q == LOCKED);
  assign bus.TriesLeft = tries_q;
  assign bus.Stage     = state_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed and randomized bench for atm_keypad_frontend against a
// transaction-level model of the keypad entry and authentication rules.
module tb_atm_keypad_frontend;

  localparam int MAX_TRIES     = 3;
  localparam int LOCK_CYCLES   = 16;
  localparam int DIGIT_TIMEOUT = 40;

  // Stage values as listed for the display output.
  localparam int S_ID = 0, S_PW = 1, S_PRESENT = 2, S_WAIT = 3, S_SESSION = 4, S_LOCKED = 5;

  logic Clock;
  logic Reset;

  atm_keypad_frontend_if bus ();

  atm_keypad_frontend #(
    .MAX_TRIES     (MAX_TRIES),
    .LOCK_CYCLES   (LOCK_CYCLES),
    .DIGIT_TIMEOUT (DIGIT_TIMEOUT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  int m_stage;
  int m_digits[$];
  int m_id, m_pw, m_tries, m_lock_n;
  int m_err;

  int checks = 0;
  int errors = 0;

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_stage = S_ID;
    m_digits.delete();
    m_id = 0; m_pw = 0; m_tries = MAX_TRIES; m_lock_n = 0; m_err = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic cr,
                            input logic av, input logic af, input logic se);
    int v;
    m_err = 0;
    if (m_stage == S_LOCKED) begin
      m_lock_n++;
      if (m_lock_n == LOCK_CYCLES) begin
        m_stage = S_ID;
        m_tries = MAX_TRIES;
        m_lock_n = 0;
      end
    end else if (se) begin
      if (m_stage == S_SESSION) m_tries = MAX_TRIES;
      m_stage = S_ID;
      m_id = 0; m_pw = 0;
      m_digits.delete();
    end else if (m_stage == S_ID || m_stage == S_PW) begin
      if (kv) begin
        if (kc <= 4'd9) begin
          if (m_digits.size() < 3) m_digits.push_back(int'(kc));
        end else if (kc == 4'hA) begin
          m_digits.delete();
        end else if (kc == 4'hB && m_digits.size() > 0) begin
          v = digits_value();
          m_digits.delete();
          if (v > 255) m_err = 1;
          else if (m_stage == S_ID) begin m_id = v; m_stage = S_PW; end
          else begin m_pw = v; m_stage = S_PRESENT; end
        end
      end
    end else if (m_stage == S_PRESENT) begin
      if (cr) m_stage = S_WAIT;
    end else if (m_stage == S_WAIT) begin
      if (av) begin
        if (!af) m_stage = S_SESSION;
        else begin
          m_tries--;
          m_id = 0; m_pw = 0;
          m_stage = (m_tries == 0) ? S_LOCKED : S_ID;
          m_lock_n = 0;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int cv;
    cv = (m_stage == S_PRESENT || m_stage == S_WAIT || m_stage == S_SESSION) ? 1 : 0;
    chk({tag, ".id"},     16'(bus.ID),        16'(m_id));
    chk({tag, ".pw"},     16'(bus.Password),  16'(m_pw));
    chk({tag, ".cv"},     16'(bus.CredValid), 16'(cv));
    chk({tag, ".locked"}, 16'(bus.Locked),    16'(m_stage == S_LOCKED));
    chk({tag, ".tries"},  16'(bus.TriesLeft), 16'(m_tries));
    chk({tag, ".stage"},  16'(bus.Stage),     16'(m_stage));
    chk({tag, ".err"},    16'(bus.EntryErr),  16'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives one cycle, then checks after the next fall.
  task automatic cycle(input logic kv, input logic [3:0] kc, input logic cr,
                       input logic av, input logic af, input logic se, input string tag);
    bus.KeyValid = kv; bus.KeyCode = kc; bus.CredReady = cr;
    bus.AuthValid = av; bus.AuthFail = af; bus.SessionEnd = se;
    @(negedge Clock);
    model_step(kv, kc, cr, av, af, se);
    bus.KeyValid = 1'b0; bus.KeyCode = 4'h0; bus.CredReady = 1'b0;
    bus.AuthValid = 1'b0; bus.AuthFail = 1'b0; bus.SessionEnd = 1'b0;
    check_outputs(tag);
  endtask

  task automatic key(input logic [3:0] code);
    cycle(1'b1, code, 1'b0, 1'b0, 1'b0, 1'b0, "key");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.KeyValid = 1'b0; bus.KeyCode = 4'h0; bus.CredReady = 1'b0;
    bus.AuthValid = 1'b0; bus.AuthFail = 1'b0; bus.SessionEnd = 1'b0;
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_outputs("reset");

    // ID 123, password 45, present, authenticate, end session
    key(4'd1); key(4'd2); key(4'd3); key(4'hB);
    key(4'd4); key(4'd5); key(4'hB);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, "cred_ready");
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "auth_ok");
    idle(2);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "session_end");

    // Out-of-range entry
    key(4'd3); key(4'd0); key(4'd0); key(4'hB);
    idle(1);

    // Fourth digit dropped, clear, then ID 7; SessionEnd keeps TriesLeft
    key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'hA); key(4'd7); key(4'hB);
    key(4'hB);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "abort");

    // Three failed attempts -> lockout, keys ignored, then recovery
    for (int a = 0; a < MAX_TRIES; a++) begin
      key(4'd5); key(4'hB); key(4'd6); key(4'hB);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, "auth_early");
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, "cred_ready");
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, "auth_fail");
    end
    key(4'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "locked_se");
    idle(LOCK_CYCLES);
    key(4'd8); key(4'hB);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic kv, cr, av, af, se;
      logic [3:0] kc;
      kv = ($urandom_range(0, 1) == 0);
      kc = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) kc = 4'($urandom_range(0, 2));
      cr = ($urandom_range(0, 1) == 0);
      av = ($urandom_range(0, 3) == 0);
      af = ($urandom_range(0, 1) == 0);
      se = ($urandom_range(0, 49) == 0);
      cycle(kv, kc, cr, av, af, se, "rand");
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "rand_end");
    idle(LOCK_CYCLES + 2);

    // Asynchronous reset in PASS_ENTRY with 42 accumulated
    key(4'd9); key(4'hB); key(4'd4); key(4'd2);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge Clock);
    Reset = 1'b0;
    key(4'hB);
    key(4'd1); key(4'hB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
